// File: rtl/conv_window_scheduler.sv
// Raster-scan window scheduler for a KxK convolution datapath: paces pixel intake,
// tracks the window centre and hands one result per interior pixel to the consumer.
//
// state  | meaning
// IDLE   | waiting for i_start, kernel bank may be re-latched
// ACTIVE | accepting pixels of the current frame
// DRAIN  | all pixels taken, waiting for the last result to be consumed
module conv_window_scheduler #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int KERNEL     = 3,
  parameter int KSEL_WIDTH = 2,
  parameter int CW         = $clog2(IMG_WIDTH),
  parameter int RW         = $clog2(IMG_HEIGHT)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [KSEL_WIDTH-1:0] i_kernel_sel,
  input  logic                  i_pix_valid,
  output logic                  o_pix_ready,
  output logic                  o_shift_en,
  output logic [KSEL_WIDTH-1:0] o_kernel_sel,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [CW-1:0]         o_out_col,
  output logic [RW-1:0]         o_out_row,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_MIN  = CW'(KERNEL - 1);
  localparam logic [RW-1:0] ROW_MIN  = RW'(KERNEL - 1);
  localparam logic [CW-1:0] COL_OFS  = CW'(KERNEL / 2);
  localparam logic [RW-1:0] ROW_OFS  = RW'(KERNEL / 2);

  logic [1:0]    state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          accept;
  logic          win_accept;
  logic          last_accept;

  // A pending result that the consumer is not taking stalls intake.
  assign o_pix_ready = (state == ACTIVE) && !(o_out_valid && !i_out_ready);
  assign accept      = i_pix_valid && o_pix_ready;
  assign o_shift_en  = accept;
  assign win_accept  = accept && (row >= ROW_MIN) && (col >= COL_MIN);
  assign last_accept = accept && (row == ROW_LAST) && (col == COL_LAST);
  assign o_busy      = (state == ACTIVE) || (state == DRAIN);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      col          <= '0;
      row          <= '0;
      o_kernel_sel <= '0;
      o_out_valid  <= 1'b0;
      o_out_col    <= '0;
      o_out_row    <= '0;
      o_done       <= 1'b0;
    end else if (i_abort && (state != IDLE)) begin
      state       <= IDLE;
      col         <= '0;
      row         <= '0;
      o_out_valid <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      o_done <= 1'b0;

      // A fresh window result overrides the consumer clearing the old one.
      if (win_accept) begin
        o_out_valid <= 1'b1;
        o_out_col   <= col - COL_OFS;
        o_out_row   <= row - ROW_OFS;
      end else if (i_out_ready) begin
        o_out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (i_start) begin
            state        <= ACTIVE;
            o_kernel_sel <= i_kernel_sel;
            col          <= '0;
            row          <= '0;
          end
        end
        ACTIVE: begin
          if (accept) begin
            if (col == COL_LAST) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
            if (last_accept) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!o_out_valid || i_out_ready) begin
            state  <= IDLE;
            o_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Bench for conv_window_scheduler on a 4x4 image with a 3x3 kernel, checked each
// cycle against a pixel-count based reference model.
module tb_conv_window_scheduler;
  localparam int W = 4;
  localparam int H = 4;
  localparam int K = 3;
  localparam int NOUT = (W - K + 1) * (H - K + 1);

  logic       clk = 1'b0;
  logic       rst_n, start, abort, pix_valid, out_ready;
  logic [1:0] ksel_in;
  logic       pix_ready, shift_en, out_valid, busy, done;
  logic [1:0] ksel_out, out_col, out_row;

  always #5 clk = ~clk;

  conv_window_scheduler #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .KERNEL(K), .KSEL_WIDTH(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
    .i_kernel_sel(ksel_in), .i_pix_valid(pix_valid), .o_pix_ready(pix_ready),
    .o_shift_en(shift_en), .o_kernel_sel(ksel_out), .o_out_valid(out_valid),
    .i_out_ready(out_ready), .o_out_col(out_col), .o_out_row(out_row),
    .o_busy(busy), .o_done(done)
  );

  int vectors = 0;
  int errs = 0;

  // Reference model: frame phase flags plus number of pixels taken this frame.
  bit   m_act, m_drn, m_ov, m_done;
  int   m_cnt, m_oc, m_or;
  logic [1:0] m_ksel;

  int got_c[$];
  int got_r[$];
  int done_cnt;
  int exp_c[4] = '{1, 2, 1, 2};
  int exp_r[4] = '{1, 1, 2, 2};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit rdy, acc, was_idle, was_drn;
    int col, row;
    #1;
    rdy = m_act && !(m_ov && !out_ready);
    chk("pix_ready", 32'(pix_ready), 32'(rdy));
    chk("shift_en", 32'(shift_en), 32'(pix_valid && rdy));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    if (m_ov) begin
      chk("out_col", 32'(out_col), m_oc);
      chk("out_row", 32'(out_row), m_or);
    end
    chk("busy", 32'(busy), 32'(m_act || m_drn));
    chk("done", 32'(done), 32'(m_done));
    chk("kernel_sel", 32'(ksel_out), 32'(m_ksel));
    if (out_valid === 1'b1 && out_ready && rst_n) begin
      got_c.push_back(int'(out_col));
      got_r.push_back(int'(out_row));
    end
    if (done === 1'b1) done_cnt++;

    acc      = pix_valid && rdy;
    col      = m_cnt % W;
    row      = m_cnt / W;
    was_idle = !m_act && !m_drn;
    was_drn  = m_drn;
    if (!rst_n) begin
      m_act = 0; m_drn = 0; m_ov = 0; m_done = 0;
      m_cnt = 0; m_oc = 0; m_or = 0; m_ksel = '0;
    end else begin
      m_done = 0;
      if (abort && !was_idle) begin
        m_act = 0; m_drn = 0; m_ov = 0; m_cnt = 0;
      end else begin
        if (was_drn && (!m_ov || out_ready)) begin
          m_drn = 0; m_done = 1;
        end
        if (was_idle && start) begin
          m_act = 1; m_ksel = ksel_in; m_cnt = 0;
        end
        if (acc && row >= K - 1 && col >= K - 1) begin
          m_ov = 1; m_oc = col - K / 2; m_or = row - K / 2;
        end else if (out_ready) begin
          m_ov = 0;
        end
        if (acc) begin
          m_cnt++;
          if (m_cnt == W * H) begin
            m_act = 0; m_drn = 1;
          end
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic stream(input int vpct, input int rpct, input int budget);
    int n = 0;
    while ((m_act || m_drn) && n < budget) begin
      pix_valid = ($urandom_range(99) < vpct);
      out_ready = ($urandom_range(99) < rpct);
      tick();
      n++;
    end
    pix_valid = 0;
    out_ready = 1;
    chk("frame_timeout", 32'(busy), 32'(0));
  endtask

  task automatic frame_check(input int exp_done);
    int n;
    chk("out_count", got_c.size(), NOUT);
    n = (got_c.size() < NOUT) ? got_c.size() : NOUT;
    for (int i = 0; i < n; i++) begin
      chk("raster_col", got_c[i], exp_c[i]);
      chk("raster_row", got_r[i], exp_r[i]);
    end
    chk("done_count", done_cnt, exp_done);
    got_c.delete();
    got_r.delete();
    done_cnt = 0;
  endtask

  initial begin
    int n;
    rst_n = 0; start = 0; abort = 0; pix_valid = 0; out_ready = 1; ksel_in = 0;
    m_act = 0; m_drn = 0; m_ov = 0; m_done = 0;
    m_cnt = 0; m_oc = 0; m_or = 0; m_ksel = '0; done_cnt = 0;
    @(posedge clk);
    @(negedge clk);
    tick();
    rst_n = 1;
    tick();

    // Full-rate frame, kernel bank 2.
    ksel_in = 2; start = 1;
    tick();
    start = 0; ksel_in = 0;
    stream(100, 100, 60);
    tick();
    frame_check(1);

    // Backpressure after the first result; start/kernel changes mid-frame.
    ksel_in = 1; start = 1;
    tick();
    start = 0; pix_valid = 1; out_ready = 1;
    n = 0;
    while (out_valid !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    chk("first_out_seen", 32'(out_valid), 32'(1));
    out_ready = 0; ksel_in = 3; start = 1;
    for (int i = 0; i < 5; i++) tick();
    start = 0;
    stream(60, 70, 300);
    tick();
    frame_check(1);

    // Abort after ten pixels, then a fresh randomized frame.
    ksel_in = 2; start = 1;
    tick();
    start = 0; pix_valid = 1; out_ready = 1;
    n = 0;
    while (m_cnt < 10 && n < 40) begin
      tick();
      n++;
    end
    abort = 1;
    tick();
    abort = 0; pix_valid = 0;
    for (int i = 0; i < 3; i++) tick();
    chk("abort_no_done", done_cnt, 0);
    got_c.delete(); got_r.delete(); done_cnt = 0;
    ksel_in = 3; start = 1;
    tick();
    start = 0;
    stream(50, 50, 400);
    tick();
    frame_check(1);

    // Reset while waiting in DRAIN.
    ksel_in = 1; start = 1;
    tick();
    start = 0; pix_valid = 1; out_ready = 1;
    n = 0;
    while (m_cnt < W * H && n < 60) begin
      tick();
      n++;
    end
    pix_valid = 0; out_ready = 0;
    for (int i = 0; i < 3; i++) tick();
    chk("drain_busy", 32'(busy), 32'(1));
    rst_n = 0;
    tick();
    rst_n = 1; out_ready = 1;
    for (int i = 0; i < 3; i++) tick();
    chk("reset_no_done", done_cnt, 0);
    got_c.delete(); got_r.delete(); done_cnt = 0;

    // One more randomized frame after reset.
    ksel_in = 0; start = 1;
    tick();
    start = 0;
    stream(40, 60, 500);
    tick();
    frame_check(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/conv_window_scheduler.md
CONV_WINDOW_SCHEDULER -- requirements
Module: conv_window_scheduler

Interface
REQ-001 Parameter IMG_WIDTH, default 640, sets the active pixels per line.
REQ-002 Parameter IMG_HEIGHT, default 480, sets the active lines per frame.
REQ-003 Parameter KERNEL, default 3, sets the odd window edge length (3..7) matching the convolution datapath.
REQ-004 Parameter KSEL_WIDTH, default 2, sets the width of the kernel-bank selector.
REQ-005 Derived widths SHALL be CW = $clog2(IMG_WIDTH) and RW = $clog2(IMG_HEIGHT).
REQ-006 Port i_clk, input, 1, is the single clock for all logic.
REQ-007 Port i_rst_n, input, 1, is a synchronous, active-low reset.
REQ-008 Port i_start, input, 1, is a frame start request sampled in IDLE only.
REQ-009 Port i_abort, input, 1, is a synchronous frame abort.
REQ-010 Port i_kernel_sel, input, KSEL_WIDTH, is the kernel bank requested for the next frame.
REQ-011 Port i_pix_valid, input, 1, is the upstream pixel valid.
REQ-012 Port o_pix_ready, output, 1, is the upstream pixel ready.
REQ-013 Port o_shift_en, output, 1, advances the line buffers/window registers (combinational accept strobe).
REQ-014 Port o_kernel_sel, output, KSEL_WIDTH, is the kernel bank latched for the current frame.
REQ-015 Port o_out_valid, output, 1, qualifies the convolution result.
REQ-016 Port i_out_ready, input, 1, is the downstream ready.
REQ-017 Port o_out_col, output, CW, is the column of the window centre for the current result.
REQ-018 Port o_out_row, output, RW, is the row of the window centre for the current result.
REQ-019 Port o_busy, output, 1, is high in ACTIVE and DRAIN.
REQ-020 Port o_done, output, 1, is a one-cycle frame-complete pulse.

Function
REQ-021 The FSM SHALL have states IDLE, ACTIVE and DRAIN.
REQ-022 In IDLE, a high i_start SHALL move to ACTIVE next cycle, latch i_kernel_sel into o_kernel_sel, and clear col/row counters.
REQ-023 i_start SHALL be ignored outside IDLE; o_kernel_sel SHALL change only at an accepted start.
REQ-024 o_pix_ready SHALL be 1 only in ACTIVE and when not (o_out_valid && !i_out_ready).
REQ-025 accept = i_pix_valid && o_pix_ready; o_shift_en SHALL equal accept combinationally.
REQ-026 On accept, col SHALL increment; at col == IMG_WIDTH-1 it SHALL wrap to 0 and row SHALL increment.
REQ-027 An accept with row >= KERNEL-1 and col >= KERNEL-1 SHALL set o_out_valid the next cycle, with o_out_col = col-KERNEL/2 and o_out_row = row-KERNEL/2, both registered.
REQ-028 o_out_valid and its coordinates SHALL hold stable until a cycle with i_out_ready = 1; that cycle clears o_out_valid unless a new window accept sets it again (set wins).
REQ-029 Border accepts (row < KERNEL-1 or col < KERNEL-1) SHALL shift the buffers but produce no output.
REQ-030 An accept at row == IMG_HEIGHT-1 and col == IMG_WIDTH-1 SHALL move to DRAIN; no further accepts SHALL occur.
REQ-031 DRAIN SHALL go to IDLE with o_done = 1 for one cycle once o_out_valid is 0, or in the cycle o_out_valid && i_out_ready.
REQ-032 i_abort in ACTIVE or DRAIN SHALL force IDLE next cycle, clear o_out_valid and the counters, and suppress o_done; i_abort SHALL take priority over all other events.
REQ-033 Output count per frame SHALL be exactly (IMG_WIDTH-KERNEL+1)*(IMG_HEIGHT-KERNEL+1).

Reset
REQ-034 While i_rst_n = 0 at a clock edge, the FSM SHALL enter IDLE with counters, o_kernel_sel, o_out_col, o_out_row, o_out_valid and o_done at 0; o_pix_ready, o_shift_en and o_busy SHALL be 0.
REQ-035 Reset mid-frame SHALL discard the frame with no o_done pulse; reset SHALL have priority over i_abort.

Verification (IMG_WIDTH=4, IMG_HEIGHT=4, KERNEL=3)
REQ-036 Start with i_kernel_sel=2, stream 16 pixels, i_out_ready=1 -> o_kernel_sel=2; exactly 4 outputs at (col,row)=(1,1),(2,1),(1,2),(2,2); o_done pulses once, one cycle after the last output.
REQ-037 Hold i_out_ready=0 after the first output -> o_pix_ready drops; coordinates (1,1) held; no accepts until i_out_ready=1.
REQ-038 Pulse i_start and change i_kernel_sel mid-frame -> no effect; o_kernel_sel stays latched.
REQ-039 Assert i_abort after 10 pixels -> IDLE next cycle, o_out_valid=0, no o_done; a new start yields 4 fresh outputs.
REQ-040 Drive i_rst_n=0 for one cycle during DRAIN -> all outputs 0 next cycle, no o_done.
REQ-041 Toggle i_pix_valid randomly -> output count 4 and coordinates in raster order.
